// File: rtl/psd_lock_fsm.sv
// psd_lock_fsm: serial code entry lock with unlock hold, retry lockout and in-field password change
module psd_lock_fsm #(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 500,
  parameter int LOCK_CYCLES = 1000,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_PSD = (DIGIT_W*NUM_DIGITS)'(16'h1234)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DIGIT_W-1:0]                 digit_in,
  input  logic                               digit_valid,
  input  logic                               clear,
  input  logic                               set_mode,
  output logic                               ledg,
  output logic                               ledr,
  output logic                               locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_cnt
);
  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int CW     = $clog2(NUM_DIGITS + 1);
  localparam int TRW    = $clog2(MAX_TRIES + 1);
  localparam int TMAX   = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, SET, LOCKOUT} state_t;
  state_t              state_q;
  logic [CODE_W-1:0]   psd_q, shift_q, shift_nx;
  logic [CW-1:0]       cnt_q;
  logic [TRW-1:0]      tries_q;
  logic [TW-1:0]       timer_q;
  logic                ledg_q, ledr_q, locked_q, last;
  assign shift_nx   = {shift_q[CODE_W-DIGIT_W-1:0], digit_in};
  assign last       = cnt_q == CW'(NUM_DIGITS - 1);
  assign ledg       = ledg_q;
  assign ledr       = ledr_q;
  assign locked_out = locked_q;
  assign tries_left = tries_q;
  assign digit_cnt  = cnt_q;
  // The fail count is kept implicitly as MAX_TRIES - tries_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      psd_q    <= DEFAULT_PSD;
      shift_q  <= '0;
      cnt_q    <= '0;
      tries_q  <= TRW'(MAX_TRIES);
      timer_q  <= '0;
      ledg_q   <= 1'b0;
      ledr_q   <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ENTRY, SET: begin
          if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= ENTRY;
            ledg_q  <= 1'b0;
          end else if (digit_valid) begin
            shift_q <= shift_nx;
            cnt_q   <= last ? '0 : cnt_q + CW'(1);
            if (last && state_q == SET) begin
              psd_q   <= shift_nx;
              state_q <= ENTRY;
              ledg_q  <= 1'b0;
            end else if (last) state_q <= CHECK;
          end
        end
        CHECK: begin
          timer_q <= '0;
          if (shift_q == psd_q) begin
            state_q <= OPEN;
            tries_q <= TRW'(MAX_TRIES);
            ledg_q  <= 1'b1;
            ledr_q  <= 1'b0;
          end else if (tries_q == TRW'(1)) begin
            state_q  <= LOCKOUT;
            tries_q  <= '0;
            locked_q <= 1'b1;
          end else begin
            state_q <= ENTRY;
            tries_q <= tries_q - TRW'(1);
          end
        end
        OPEN: begin
          if (set_mode) begin
            state_q <= SET;
            ledr_q  <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
            state_q <= ENTRY;
            ledg_q  <= 1'b0;
            ledr_q  <= 1'b1;
          end else timer_q <= timer_q + TW'(1);
        end
        LOCKOUT: begin
          if (timer_q == TW'(LOCK_CYCLES - 1)) begin
            state_q  <= ENTRY;
            locked_q <= 1'b0;
            tries_q  <= TRW'(MAX_TRIES);
          end else timer_q <= timer_q + TW'(1);
        end
        default: state_q <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_psd_lock_fsm.sv
// tb_psd_lock_fsm: directed scenarios plus random traffic checked every cycle against a queue-based model
module tb_psd_lock_fsm;
  localparam int DW = 4, ND = 4, MT = 3, OC = 500, LC = 1000;
  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;
  logic clk = 0, rst_n = 0, digit_valid = 0, clear = 0, set_mode = 0;
  logic [3:0] digit_in = 0;
  logic ledg, ledr, locked_out;
  logic [1:0] tries_left;
  logic [2:0] digit_cnt;
  int n_cmp = 0, n_bad = 0;
  int mode, rem, fails, pw, pend;
  int q[$];
  always #5 clk = ~clk;
  psd_lock_fsm dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .set_mode(set_mode), .ledg(ledg), .ledr(ledr),
    .locked_out(locked_out), .tries_left(tries_left), .digit_cnt(digit_cnt)
  );
  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic void m_reset();
    mode = M_ENTRY; rem = 0; fails = 0; pw = 'h1234; pend = 0; q.delete();
  endfunction
  function automatic int pack();
    int c = 0;
    foreach (q[i]) c = c * (1 << DW) + q[i];
    return c;
  endfunction
  // One clock of the behavioural model: digits queue up, a full queue becomes a code.
  function automatic void m_step(bit dv, int d, bit clr, bit sm);
    case (mode)
      M_ENTRY, M_SET: begin
        if (clr) begin
          q.delete(); mode = M_ENTRY;
        end else if (dv) begin
          q.push_back(d);
          if (q.size() == ND) begin
            if (mode == M_SET) begin pw = pack(); mode = M_ENTRY; end
            else begin pend = pack(); mode = M_CHECK; end
            q.delete();
          end
        end
      end
      M_CHECK: begin
        if (pend == pw) begin fails = 0; mode = M_OPEN; rem = OC; end
        else begin
          fails++;
          if (fails == MT) begin mode = M_LOCK; rem = LC; end else mode = M_ENTRY;
        end
      end
      M_OPEN: begin
        if (sm) begin mode = M_SET; q.delete(); end
        else begin rem--; if (rem == 0) mode = M_ENTRY; end
      end
      default: begin
        rem--;
        if (rem == 0) begin mode = M_ENTRY; fails = 0; end
      end
    endcase
  endfunction
  task automatic compare_all();
    chk("ledg", ledg, int'(mode == M_OPEN || mode == M_SET));
    chk("ledr", ledr, int'(mode != M_OPEN));
    chk("locked_out", locked_out, int'(mode == M_LOCK));
    chk("tries_left", tries_left, MT - fails);
    chk("digit_cnt", digit_cnt, q.size());
  endtask
  task automatic cyc(bit dv, int d, bit clr, bit sm);
    digit_valid = dv; digit_in = 4'(d); clear = clr; set_mode = sm;
    @(posedge clk);
    if (rst_n) m_step(dv, d & 15, clr, sm);
    #1 compare_all();
  endtask
  task automatic enter(int code);
    for (int i = ND - 1; i >= 0; i--) cyc(1, (code >> (DW * i)) & 15, 0, 0);
  endtask
  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic arst(string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, "_ledg"}, ledg, 0);
    chk({tag, "_ledr"}, ledr, 1);
    chk({tag, "_locked"}, locked_out, 0);
    chk({tag, "_tries"}, tries_left, MT);
    chk({tag, "_cnt"}, digit_cnt, 0);
    m_reset();
    digit_valid = 0; clear = 0; set_mode = 0;
    @(posedge clk);
    #1 compare_all();
    rst_n = 1;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, r, d;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ledg", ledg, 0);
    chk("rst_ledr", ledr, 1);
    chk("rst_locked", locked_out, 0);
    chk("rst_tries", tries_left, 3);
    chk("rst_cnt", digit_cnt, 0);
    rst_n = 1;
    idle(1);
    enter('h1234);
    chk("ledg_in_check", ledg, 0);
    idle(1);
    chk("ledg_2cyc", ledg, 1);
    chk("ledr_open", ledr, 0);
    n = 1;
    for (int i = 0; i < 2000 && ledg; i++) begin
      idle(1);
      if (ledg) n++;
    end
    chk("open_len", n, 500);
    chk("ledr_after_open", ledr, 1);
    chk("tries_after_open", tries_left, 3);
    enter('h1235); idle(1);
    chk("tries_after_miss", tries_left, 2);
    enter('h1234); idle(1);
    chk("unlock_after_miss", ledg, 1);
    chk("tries_restored", tries_left, 3);
    idle(OC);
    repeat (3) begin enter('h1235); idle(1); end
    chk("lock_locked", locked_out, 1);
    chk("lock_tries", tries_left, 0);
    n = 1;
    for (int i = 0; i < 2000 && locked_out; i++) begin
      cyc(1, i % 4 + 1, 0, 0);
      if (locked_out) n++;
    end
    chk("lock_len", n, 1000);
    chk("tries_after_lock", tries_left, 3);
    cyc(0, 0, 1, 0);
    enter('h1234); idle(1);
    chk("set_pre_open", ledg, 1);
    cyc(0, 0, 0, 1);
    chk("set_ledg", ledg, 1);
    chk("set_ledr", ledr, 1);
    enter('h9876);
    chk("set_done_ledg", ledg, 0);
    enter('h1234); idle(1);
    chk("old_pw_rejected", ledg, 0);
    chk("old_pw_tries", tries_left, 2);
    enter('h9876); idle(1);
    chk("new_pw_unlocks", ledg, 1);
    idle(20);
    arst("arst_open");
    enter('h1234); idle(1);
    chk("default_pw_back", ledg, 1);
    idle(OC);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
    chk("partial_cnt", digit_cnt, 2);
    cyc(0, 0, 1, 0);
    chk("clear_cnt", digit_cnt, 0);
    enter('h1234); idle(1);
    chk("unlock_after_clear", ledg, 1);
    idle(OC);
    cyc(1, 5, 1, 0);
    chk("dv_clear_drop", digit_cnt, 0);
    repeat (3) begin enter('h1111); idle(1); end
    idle(100);
    chk("mid_lock", locked_out, 1);
    arst("arst_lock");
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom_range(0, 1) ? (pw >> (DW * (ND - 1 - q.size()))) & 15 : $urandom_range(0, 15);
      cyc(r < 45, d, r >= 95 || r == 0, r >= 88 && r < 95);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/psd_lock_fsm.md
Name: psd_lock_fsm

Overview:
- Parametrised sequential successor to the combinational password comparator.
- Collects a serially entered code one digit at a time and compares it against a stored password held in a register.
- Adds an unlock hold timer, a failed-attempt counter with timed lockout, and in-field password change.
- Sits between the keypad digit decoder and the lock/LED drivers.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- NUM_DIGITS, 4, digits per code; code width CODE_W = DIGIT_W*NUM_DIGITS.
- MAX_TRIES, 3, consecutive mismatches that trigger lockout (must be ≥1).
- OPEN_CYCLES, 500, clock cycles ledg stays asserted after a match.
- LOCK_CYCLES, 1000, clock cycles of lockout.
- DEFAULT_PSD, 16'h1234 (sized CODE_W), password loaded at reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- digit_in  in  DIGIT_W  entered digit value.
- digit_valid  in  1  single-cycle strobe; digit_in is sampled when high.
- clear  in  1  aborts the entry in progress.
- set_mode  in  1  requests a password change; honoured only in OPEN.
- ledg  out  1  unlocked indicator.
- ledr  out  1  locked indicator.
- locked_out  out  1  high during lockout.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout.
- digit_cnt  out  $clog2(NUM_DIGITS+1)  digits captured so far in the current entry.

Behaviour:
- Reset (async, rst_n=0):
  - state=ENTRY, password register=DEFAULT_PSD, shift register=0, digit_cnt=0.
  - fail count=0, so tries_left=MAX_TRIES.
  - ledg=0, ledr=1, locked_out=0, all timers=0.
- All outputs are registered. The password register changes only at reset or on SET completion.
- Digit capture: each digit_valid shifts digit_in into the LSB end, so the first digit lands in the MSB. digit_cnt increments on each accepted digit.
- ENTRY:
  - Digits are accepted.
  - When the NUM_DIGITS-th digit is accepted, go to CHECK next cycle; digit_cnt resets to 0.
  - clear (priority over digit_valid in the same cycle) zeroes the shift register and digit_cnt and stays in ENTRY.
- CHECK: one cycle. Compares shift register with password; digit_valid is ignored.
  - Match: fail count cleared, go to OPEN.
  - Mismatch: fail count +1. If the new count equals MAX_TRIES go to LOCKOUT, else go to ENTRY.
  - Match-to-ledg latency: ledg rises 2 cycles after the last digit strobe.
- OPEN:
  - ledg=1, ledr=0, timer counts OPEN_CYCLES, then return to ENTRY with ledg=0, ledr=1.
  - set_mode (sampled any cycle in OPEN) goes to SET, cancelling the timer.
  - Digits and clear are ignored except as stated for SET.
- SET:
  - ledg=1, ledr=1 (both lit = programming).
  - Collects NUM_DIGITS digits the same way as ENTRY. On the last digit, the password register loads the new code next cycle, then go to ENTRY.
  - clear aborts to ENTRY with the password unchanged.
  - No timeout.
- LOCKOUT:
  - locked_out=1, ledr=1, ledg=0; all inputs ignored.
  - After LOCK_CYCLES go to ENTRY, with fail count cleared and tries_left=MAX_TRIES.
- tries_left = MAX_TRIES − fail count, updated the cycle after CHECK. It is 0 throughout LOCKOUT.
- Simultaneous digit_valid and clear: clear wins and the digit is dropped.
- Reset mid-operation aborts everything. A password changed via SET is lost and reverts to DEFAULT_PSD.
- Timers must be wide enough for max(OPEN_CYCLES, LOCK_CYCLES) and must not wrap.

Test Plan:
- Reset, then enter digits 1,2,3,4 → ledg=1/ledr=0 two cycles after the 4th strobe, held exactly 500 cycles, then ledg=0/ledr=1; tries_left stays 3.
- Enter 1,2,3,5 → ledr stays 1, tries_left 3→2. Enter 1,2,3,4 → OPEN, tries_left back to 3.
- Three consecutive wrong codes → locked_out=1 and tries_left=0 the cycle after the 3rd CHECK. During the next 1000 cycles, enter 1,2,3,4 → no unlock. After expiry, locked_out=0 and tries_left=3.
- Unlock, pulse set_mode, enter 9,8,7,6 → both LEDs lit during SET. Afterwards 1,2,3,4 fails and 9,8,7,6 unlocks. Assert rst_n=0 → 1,2,3,4 unlocks again.
- Enter 1,2, pulse clear, enter 1,2,3,4 → unlock (partial entry discarded, digit_cnt=0 after clear). Assert digit_valid and clear together → digit dropped.
- Drop rst_n asynchronously mid-OPEN and mid-LOCKOUT → outputs return immediately to reset values without waiting for a clock edge.
